// File: rtl/sram_sdp_aw.sv
// Simple dual-port SRAM with independent write/read widths, registered read data,
// optional output stage and selectable read-first / write-through collision policy.
module sram_sdp_aw #(
  parameter int unsigned WRITE_WIDTH = 4,
  parameter int unsigned READ_WIDTH  = 16,
  parameter int unsigned DEPTH       = 8,
  parameter int unsigned OUT_REG     = 0,
  parameter int unsigned READ_MODE   = 0,
  parameter int unsigned WRITE_ADDR  = $clog2(DEPTH) +
    ((WRITE_WIDTH < READ_WIDTH) ? $clog2(READ_WIDTH / WRITE_WIDTH) : 0),
  parameter int unsigned READ_ADDR   = $clog2(DEPTH) +
    ((READ_WIDTH < WRITE_WIDTH) ? $clog2(WRITE_WIDTH / READ_WIDTH) : 0)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   wr_en_i,
  input  logic [WRITE_ADDR-1:0]  wr_addr_i,
  input  logic [WRITE_WIDTH-1:0] wr_data_i,
  input  logic                   rd_en_i,
  input  logic [READ_ADDR-1:0]   rd_addr_i,
  output logic [READ_WIDTH-1:0]  rd_data_o,
  output logic                   rd_valid_o
);

  localparam int unsigned MIN_W = (WRITE_WIDTH < READ_WIDTH) ? WRITE_WIDTH : READ_WIDTH;
  localparam int unsigned MAX_W = (WRITE_WIDTH < READ_WIDTH) ? READ_WIDTH : WRITE_WIDTH;
  localparam int unsigned RATIO = MAX_W / MIN_W;
  localparam int unsigned LANES = DEPTH * RATIO;
  localparam int unsigned LW    = $clog2(LANES);
  // Number of lanes each port touches per access.
  localparam int unsigned WR_N  = (WRITE_WIDTH > READ_WIDTH) ? RATIO : 1;
  localparam int unsigned RD_N  = (READ_WIDTH > WRITE_WIDTH) ? RATIO : 1;

  if ((MAX_W % MIN_W) != 0 || (RATIO & (RATIO - 1)) != 0 ||
      DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_geometry
    $fatal(1, "sram_sdp_aw: widths must differ by a power-of-two ratio and DEPTH must be a power of two >= 2");
  end
  if (WRITE_ADDR != LW - $clog2(WR_N) || READ_ADDR != LW - $clog2(RD_N)) begin : g_bad_addr
    $fatal(1, "sram_sdp_aw: address widths inconsistent with DEPTH and widths");
  end

  logic [MIN_W-1:0]      mem [LANES];
  logic [LW-1:0]         wr_base;
  logic [LW-1:0]         rd_base;
  logic [READ_WIDTH-1:0] rd_word_c;
  logic [READ_WIDTH-1:0] s1_data;
  logic                  s1_valid;

  assign wr_base = LW'(wr_addr_i) << $clog2(WR_N);
  assign rd_base = LW'(rd_addr_i) << $clog2(RD_N);

  // Lane storage; not reset, writes suppressed while in reset.
  always_ff @(posedge clk_i) begin
    if (wr_en_i && !rst_i) begin
      for (int j = 0; j < WR_N; j++) begin
        mem[wr_base + LW'(j)] <= wr_data_i[j*MIN_W +: MIN_W];
      end
    end
  end

  // Assemble read lanes little-endian, overlaying same-edge write data in write-through mode.
  always_comb begin
    logic [LW-1:0] lane;
    logic [LW-1:0] off;
    rd_word_c = '0;
    lane      = '0;
    off       = '0;
    for (int j = 0; j < RD_N; j++) begin
      lane = rd_base + LW'(j);
      off  = lane - wr_base;
      rd_word_c[j*MIN_W +: MIN_W] = mem[lane];
      if (READ_MODE == 1 && wr_en_i && off < LW'(WR_N)) begin
        rd_word_c[j*MIN_W +: MIN_W] = wr_data_i[int'(off)*MIN_W +: MIN_W];
      end
    end
  end

  // First read stage: data only updates on an accepted read, so it holds otherwise.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_data  <= '0;
      s1_valid <= 1'b0;
    end else begin
      s1_valid <= rd_en_i;
      if (rd_en_i) begin
        s1_data <= rd_word_c;
      end
    end
  end

  if (OUT_REG != 0) begin : g_out_reg
    logic [READ_WIDTH-1:0] s2_data;
    logic                  s2_valid;

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        s2_data  <= '0;
        s2_valid <= 1'b0;
      end else begin
        s2_data  <= s1_data;
        s2_valid <= s1_valid;
      end
    end

    assign rd_data_o  = s2_data;
    assign rd_valid_o = s2_valid;
  end else begin : g_no_out_reg
    assign rd_data_o  = s1_data;
    assign rd_valid_o = s1_valid;
  end

endmodule

// File: tb/tb_sram_sdp_aw.sv
// Directed bench for sram_sdp_aw: narrow/wide writes, both collision policies,
// two-stage latency and asynchronous reset during an in-flight read.
module tb_sram_sdp_aw;

  logic clk = 1'b0;
  logic rst;
  logic d_rst;

  // Shared stimulus for the read-first (a) and write-through (b) instances.
  logic        ab_wr_en;
  logic [4:0]  ab_wr_addr;
  logic [3:0]  ab_wr_data;
  logic        ab_rd_en;
  logic [2:0]  ab_rd_addr;
  logic [15:0] a_rd_data, b_rd_data;
  logic        a_rd_valid, b_rd_valid;

  logic        c_wr_en;
  logic [2:0]  c_wr_addr;
  logic [15:0] c_wr_data;
  logic        c_rd_en;
  logic [4:0]  c_rd_addr;
  logic [3:0]  c_rd_data;
  logic        c_rd_valid;

  logic        d_wr_en;
  logic [4:0]  d_wr_addr;
  logic [3:0]  d_wr_data;
  logic        d_rd_en;
  logic [2:0]  d_rd_addr;
  logic [15:0] d_rd_data;
  logic        d_rd_valid;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sram_sdp_aw #(.WRITE_WIDTH(4), .READ_WIDTH(16), .DEPTH(8), .OUT_REG(0), .READ_MODE(0)) u_a (
    .clk_i(clk), .rst_i(rst), .wr_en_i(ab_wr_en), .wr_addr_i(ab_wr_addr), .wr_data_i(ab_wr_data),
    .rd_en_i(ab_rd_en), .rd_addr_i(ab_rd_addr), .rd_data_o(a_rd_data), .rd_valid_o(a_rd_valid));

  sram_sdp_aw #(.WRITE_WIDTH(4), .READ_WIDTH(16), .DEPTH(8), .OUT_REG(0), .READ_MODE(1)) u_b (
    .clk_i(clk), .rst_i(rst), .wr_en_i(ab_wr_en), .wr_addr_i(ab_wr_addr), .wr_data_i(ab_wr_data),
    .rd_en_i(ab_rd_en), .rd_addr_i(ab_rd_addr), .rd_data_o(b_rd_data), .rd_valid_o(b_rd_valid));

  sram_sdp_aw #(.WRITE_WIDTH(16), .READ_WIDTH(4), .DEPTH(8), .OUT_REG(0), .READ_MODE(0)) u_c (
    .clk_i(clk), .rst_i(rst), .wr_en_i(c_wr_en), .wr_addr_i(c_wr_addr), .wr_data_i(c_wr_data),
    .rd_en_i(c_rd_en), .rd_addr_i(c_rd_addr), .rd_data_o(c_rd_data), .rd_valid_o(c_rd_valid));

  sram_sdp_aw #(.WRITE_WIDTH(4), .READ_WIDTH(16), .DEPTH(8), .OUT_REG(1), .READ_MODE(0)) u_d (
    .clk_i(clk), .rst_i(d_rst), .wr_en_i(d_wr_en), .wr_addr_i(d_wr_addr), .wr_data_i(d_wr_data),
    .rd_en_i(d_rd_en), .rd_addr_i(d_rd_addr), .rd_data_o(d_rd_data), .rd_valid_o(d_rd_valid));

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [15:0] beef;
    logic [3:0]  d_vals [8];
    beef   = 16'hBEEF;
    d_vals = '{4'h9, 4'h8, 4'h7, 4'h6, 4'h1, 4'h2, 4'h3, 4'h4};

    rst = 1'b0; d_rst = 1'b0;
    ab_wr_en = 1'b0; ab_wr_addr = '0; ab_wr_data = '0; ab_rd_en = 1'b0; ab_rd_addr = '0;
    c_wr_en = 1'b0; c_wr_addr = '0; c_wr_data = '0; c_rd_en = 1'b0; c_rd_addr = '0;
    d_wr_en = 1'b0; d_wr_addr = '0; d_wr_data = '0; d_rd_en = 1'b0; d_rd_addr = '0;

    #1 rst = 1'b1; d_rst = 1'b1;
    #1;
    chk("rst_a_valid", 16'(a_rd_valid), 16'h0);
    chk("rst_a_data", a_rd_data, 16'h0);
    chk("rst_c_data", 16'(c_rd_data), 16'h0);
    chk("rst_d_valid", 16'(d_rd_valid), 16'h0);
    chk("rst_d_data", d_rd_data, 16'h0);
    step(); step();
    rst = 1'b0; d_rst = 1'b0;

    // Narrow write of four lanes, then one wide read
    for (int i = 0; i < 4; i++) begin
      ab_wr_en = 1'b1; ab_wr_addr = 5'(i); ab_wr_data = 4'(i + 1);
      step();
    end
    ab_wr_en = 1'b0;
    ab_rd_en = 1'b1; ab_rd_addr = 3'd0;
    step();
    chk("narrow_a_valid", 16'(a_rd_valid), 16'h1);
    chk("narrow_a_data", a_rd_data, 16'h4321);
    chk("narrow_b_data", b_rd_data, 16'h4321);
    ab_rd_en = 1'b0;
    step();
    chk("narrow_valid_drop", 16'(a_rd_valid), 16'h0);
    chk("narrow_data_hold", a_rd_data, 16'h4321);

    // Collision: word 1 = AAAA, then write lane 6 while reading word 1
    for (int i = 4; i < 8; i++) begin
      ab_wr_en = 1'b1; ab_wr_addr = 5'(i); ab_wr_data = 4'hA;
      step();
    end
    ab_wr_en = 1'b1; ab_wr_addr = 5'd6; ab_wr_data = 4'h5;
    ab_rd_en = 1'b1; ab_rd_addr = 3'd1;
    step();
    chk("coll_rf_data", a_rd_data, 16'hAAAA);
    chk("coll_wt_data", b_rd_data, 16'hA5AA);
    chk("coll_wt_valid", 16'(b_rd_valid), 16'h1);
    ab_wr_en = 1'b0;
    step();
    chk("reread_rf_data", a_rd_data, 16'hA5AA);
    chk("reread_wt_data", b_rd_data, 16'hA5AA);
    ab_rd_en = 1'b0;
    step();

    // Wide write, four back-to-back narrow reads
    c_wr_en = 1'b1; c_wr_addr = 3'd2; c_wr_data = 16'hBEEF;
    step();
    c_wr_en = 1'b0;
    c_rd_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      c_rd_addr = 5'(8 + i);
      step();
      chk("wide_valid", 16'(c_rd_valid), 16'h1);
      chk("wide_lane", 16'(c_rd_data), 16'(beef[i*4 +: 4]));
    end
    c_rd_en = 1'b0;
    step();
    chk("wide_valid_drop", 16'(c_rd_valid), 16'h0);

    // Two-stage latency with back-to-back reads
    for (int i = 0; i < 8; i++) begin
      d_wr_en = 1'b1; d_wr_addr = 5'(i); d_wr_data = d_vals[i];
      step();
    end
    d_wr_en = 1'b0;
    d_rd_en = 1'b1; d_rd_addr = 3'd0;
    step();
    chk("lat_n1_valid", 16'(d_rd_valid), 16'h0);
    d_rd_addr = 3'd1;
    step();
    chk("lat_n2_valid", 16'(d_rd_valid), 16'h1);
    chk("lat_n2_data", d_rd_data, 16'h6789);
    d_rd_en = 1'b0;
    step();
    chk("lat_n3_valid", 16'(d_rd_valid), 16'h1);
    chk("lat_n3_data", d_rd_data, 16'h4321);
    step();
    chk("lat_n4_valid", 16'(d_rd_valid), 16'h0);
    chk("lat_n4_hold", d_rd_data, 16'h4321);

    // Reset with a read in flight; accesses during reset are ignored
    d_rd_en = 1'b1; d_rd_addr = 3'd0;
    step();
    d_rd_en = 1'b0;
    chk("inflight_valid", 16'(d_rd_valid), 16'h0);
    #2 d_rst = 1'b1;
    #1;
    chk("async_rst_valid", 16'(d_rd_valid), 16'h0);
    chk("async_rst_data", d_rd_data, 16'h0);
    d_wr_en = 1'b1; d_wr_addr = 5'd4; d_wr_data = 4'hF;
    d_rd_en = 1'b1; d_rd_addr = 3'd1;
    step(); step();
    d_wr_en = 1'b0; d_rd_en = 1'b0;
    d_rst = 1'b0;
    step();
    chk("post_rst_valid1", 16'(d_rd_valid), 16'h0);
    step();
    chk("post_rst_valid2", 16'(d_rd_valid), 16'h0);
    chk("post_rst_data", d_rd_data, 16'h0);
    d_rd_en = 1'b1; d_rd_addr = 3'd1;
    step();
    d_rd_en = 1'b0;
    step();
    chk("post_rst_read_valid", 16'(d_rd_valid), 16'h1);
    chk("post_rst_read_data", d_rd_data, 16'h4321);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sram_sdp_aw.md
Name: sram_sdp_aw

Overview:
- Synchronous simple dual-port SRAM model with independent, parametrised write and read widths. One write port and one registered read port share a single clock.
- Successor to the team's combinational width-mismatched SRAM model. Adds registered read data, a read-valid flag, an optional output pipeline stage, defined collision behaviour, and full width conversion in both directions.
- Used as the storage element behind width-converting FIFOs and line buffers.

Parameters:
- WRITE_WIDTH, 4: write data width in bits.
- READ_WIDTH, 16: read data width in bits.
- DEPTH, 8: number of words of the WIDER port. Must be a power of two, ≥ 2.
- OUT_REG, 0: 0 gives 1-cycle read latency; 1 adds an output register for 2-cycle latency.
- READ_MODE, 0: collision policy. 0 = read-first (old data); 1 = write-through (new data).
- WRITE_ADDR, derived: clog2(DEPTH) + clog2(RATIO) if the write port is narrower, else clog2(DEPTH).
- READ_ADDR, derived: clog2(DEPTH) + clog2(RATIO) if the read port is narrower, else clog2(DEPTH).
- RATIO (localparam): max(WRITE_WIDTH, READ_WIDTH) / min(WRITE_WIDTH, READ_WIDTH). Must be a power of two.

Ports:
- clk_i  in  1  clock, rising-edge.
- rst_i  in  1  asynchronous, active-high reset.
- wr_en_i  in  1  write strobe.
- wr_addr_i  in  WRITE_ADDR  write address, in write-width units.
- wr_data_i  in  WRITE_WIDTH  write data.
- rd_en_i  in  1  read strobe.
- rd_addr_i  in  READ_ADDR  read address, in read-width units.
- rd_data_o  out  READ_WIDTH  read data.
- rd_valid_o  out  1  rd_data_o holds the result of a read issued LAT cycles earlier.

Behaviour:
- Single clock domain. Reset is asynchronous and active-high: clk_i, rst_i.
- Storage is DEPTH×RATIO lanes of min-width bits. Wide word k consists of lanes k*RATIO .. k*RATIO+RATIO-1.
- Lane ordering is little-endian: lane 0 maps to bits [min-1:0] of the wide word.
- Narrow-port address: upper clog2(DEPTH) bits select the wide word; lower clog2(RATIO) bits select the lane.
- Write: on a rising clk_i edge with wr_en_i=1, store wr_data_i.
  - Write port narrower: exactly one lane is written; the other lanes are untouched.
  - Write port wider: all RATIO lanes of word wr_addr_i are written.
- Read: on a rising clk_i edge with rd_en_i=1, capture data.
  - Read port narrower: the addressed lane.
  - Read port wider: the full word, assembled little-endian.
- Latency LAT = 1 + OUT_REG.
  - rd_valid_o pulses high LAT cycles after each accepted read and stays high for one cycle per read.
  - Back-to-back reads give back-to-back valids at full throughput.
- rd_data_o holds its last value when no read is issued; it is not cleared after valid drops.
- With OUT_REG=1, both pipeline stages advance every cycle (no stall input).
- Collision: same edge, wr_en_i and rd_en_i both high, and the write lanes overlap the read lanes.
  - READ_MODE=0: returns pre-write contents of all read lanes.
  - READ_MODE=1: returns new data in the overlapped lanes and old data in the non-overlapped lanes.
- Reset:
  - rd_data_o = 0, rd_valid_o = 0, and all pipeline stages are cleared immediately, regardless of clk_i.
  - Memory contents are NOT cleared; unwritten lanes read as X.
  - A read in flight when reset asserts is dropped: no valid after reset release.
  - While rst_i=1, writes and reads are ignored.
- Address wrap-around: none. Addresses are full-range by construction; every address is legal.
- Equal widths (RATIO=1): plain DEPTH-word RAM with the same timing and collision rules.
- Elaboration check: $fatal if RATIO is not a power of two, max width is not a multiple of min width, or DEPTH is not a power of two.

Test Plan:
- Narrow write (W=4, R=16, DEPTH=8): write 0x1,0x2,0x3,0x4 to addr 0..3; read addr 0 → next cycle rd_data_o=0x4321, rd_valid_o=1 for exactly 1 cycle.
- Wide write (W=16, R=4): write 0xBEEF to addr 2; read addr 8,9,10,11 back-to-back → 0xF,0xE,0xE,0xB on 4 consecutive valid cycles.
- Read-first collision (READ_MODE=0, W=4, R=16): word 1 = 0xAAAA; same edge write 0x5 to addr 6 and read addr 1 → 0xAAAA; re-read → 0xA5AA.
- Write-through collision (READ_MODE=1): same stimulus as the read-first case → 0xA5AA on the first read.
- Latency (OUT_REG=1): read issued at cycle n → rd_valid_o high at n+2 only. Reads at n and n+1 → valid at n+2 and n+3.
- Reset mid-read (OUT_REG=1): read at n, rst_i high between edges n+1 and n+2 → rd_valid_o and rd_data_o drop to 0 immediately and no valid follows. Memory written before reset still reads correctly after release.
